// File: rtl/bp_pkg.sv
// Shared definitions for the PAg two-level branch predictor.
package bp_pkg;

  localparam int CNT_W_DEF = 2;

  function automatic int weak_nt(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  function automatic int sat_step(
    input int   cnt,
    input logic up,
    input int   cnt_w
  );
    int mx;
    mx = (1 << cnt_w) - 1;
    if (up)
      return (cnt >= mx) ? mx : cnt + 1;
    return (cnt <= 0) ? 0 : cnt - 1;
  endfunction

endpackage

// File: rtl/bp_local_hist_table.sv
// Per-PC local history table: two async read ports, one sync write port.
module bp_local_hist_table #(
  parameter int HIST_W    = 4,
  parameter int BHT_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [BHT_IDX_W-1:0] waddr_i,
  input  logic [HIST_W-1:0]    wdata_i,
  input  logic [BHT_IDX_W-1:0] raddr_a_i,
  output logic [HIST_W-1:0]    rdata_a_o,
  input  logic [BHT_IDX_W-1:0] raddr_b_i,
  output logic [HIST_W-1:0]    rdata_b_o
);

  localparam int DEPTH = 2 ** BHT_IDX_W;

  logic [HIST_W-1:0] hist_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        hist_q[i] <= '0;
    end else if (we_i) begin
      hist_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = hist_q[raddr_a_i];
  assign rdata_b_o = hist_q[raddr_b_i];

endmodule

// File: rtl/two_level_bp_gen2.sv
// PAg two-level branch predictor: per-PC local history feeding a shared PHT.
// Statistics counters are built only when BP_STATS_EN is defined.
module two_level_bp_gen2
  import bp_pkg::*;
#(
  parameter int HIST_W    = 4,
  parameter int BHT_IDX_W = 4,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pred_valid,
  input  logic [BHT_IDX_W-1:0] pred_pc,
  input  logic                 upd_valid,
  input  logic [BHT_IDX_W-1:0] upd_pc,
  input  logic                 upd_taken,
  input  logic                 upd_pred,
  output logic                 pre_valid,
  output logic                 pre_taken,
  output logic [31:0]          stat_lookups,
  output logic [31:0]          stat_mispred
);

  localparam int PHT_D = 2 ** HIST_W;
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(weak_nt(CNT_W));

  logic [HIST_W-1:0] pred_hist;
  logic [HIST_W-1:0] upd_hist;
  logic [HIST_W-1:0] hist_nxt;
  logic [CNT_W-1:0]  pht_q [PHT_D];
  logic [CNT_W-1:0]  cnt_d;
  logic              pre_valid_q;
  logic              pre_taken_q;

  bp_local_hist_table #(
    .HIST_W    (HIST_W),
    .BHT_IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .we_i      (upd_valid),
    .waddr_i   (upd_pc),
    .wdata_i   (hist_nxt),
    .raddr_a_i (pred_pc),
    .rdata_a_o (pred_hist),
    .raddr_b_i (upd_pc),
    .rdata_b_o (upd_hist)
  );

  generate
    if (HIST_W == 1) begin : g_h1
      assign hist_nxt = upd_taken;
    end else begin : g_hn
      assign hist_nxt = {upd_hist[HIST_W-2:0], upd_taken};
    end
  endgenerate

  always_comb begin
    cnt_d = CNT_W'(sat_step(int'(pht_q[upd_hist]), upd_taken, CNT_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_D; i++)
        pht_q[i] <= CNT_RST;
    end else if (upd_valid) begin
      pht_q[upd_hist] <= cnt_d;
    end
  end

  // Reads see pre-edge table state, so a colliding update is invisible here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_valid_q <= 1'b0;
      pre_taken_q <= 1'b0;
    end else begin
      pre_valid_q <= pred_valid;
      if (pred_valid)
        pre_taken_q <= pht_q[pred_hist][CNT_W-1];
    end
  end

  assign pre_valid = pre_valid_q;
  assign pre_taken = pre_taken_q;

`ifdef BP_STATS_EN
  logic [31:0] lookups_q;
  logic [31:0] mispred_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lookups_q <= '0;
      mispred_q <= '0;
    end else begin
      if (pred_valid && lookups_q != '1)
        lookups_q <= lookups_q + 32'd1;
      if (upd_valid && (upd_pred != upd_taken) && mispred_q != '1)
        mispred_q <= mispred_q + 32'd1;
    end
  end

  assign stat_lookups = lookups_q;
  assign stat_mispred = mispred_q;
`else
  logic unused_pred;
  assign unused_pred  = upd_pred;
  assign stat_lookups = '0;
  assign stat_mispred = '0;
`endif

endmodule
